// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_pkg
//  Purpose  : Shared AHB-Lite encodings, default-slave state type and the
//             default six-port memory map used by RTL, software and benches.
//  Revision : 1.0  initial release
// ============================================================================
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] c_htrans_idle   = 2'b00;
  localparam logic [1:0] c_htrans_busy   = 2'b01;
  localparam logic [1:0] c_htrans_nonseq = 2'b10;
  localparam logic [1:0] c_htrans_seq    = 2'b11;

  // HRESP encodings
  localparam logic c_hresp_okay  = 1'b0;
  localparam logic c_hresp_error = 1'b1;

  // Default-slave state encoding
  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  // Default memory map: port i lives in bits [32*i+31:32*i]
  localparam int c_map_ports = 6;
  localparam logic [32*c_map_ports-1:0] c_port_base_default = {
    32'h6000_0000,   // 5 FM_HW
    32'h5000_0010,   // 4 SPI
    32'h4000_0010,   // 3 UART
    32'h4000_0000,   // 2 WaterLight
    32'h2000_0000,   // 1 RAMDATA
    32'h0000_0000    // 0 RAMCODE
  };
  localparam logic [32*c_map_ports-1:0] c_port_mask_default = {
    32'hFFFE_0000,
    32'hFFFF_FFF0,
    32'hFFFF_FFF0,
    32'hFFFF_FFF0,
    32'hFFFF_0000,
    32'hFFFF_0000
  };

endpackage
`default_nettype wire

// File: rtl/ahblite_decoder_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahblite_decoder_mux_if
//  Purpose  : Bus bundle between the manager/slave side and the decoder-mux.
//             'master' is the side driving addresses and slave responses,
//             'slave' is the decoder-mux itself.
//  Revision : 1.0  initial release
// ============================================================================
interface ahblite_decoder_mux_if #(
  parameter int NUM_PORTS = 6,
  parameter int DATA_W    = 32
);
  logic [31:0]                 HADDR;
  logic [1:0]                  HTRANS;
  logic [NUM_PORTS-1:0]        HSEL_O;
  logic [NUM_PORTS-1:0]        HREADYOUT_I;
  logic [NUM_PORTS-1:0]        HRESP_I;
  logic [NUM_PORTS*DATA_W-1:0] HRDATA_I;
  logic                        HREADY;
  logic                        HRESP;
  logic [DATA_W-1:0]           HRDATA;

  modport master (
    output HADDR, HTRANS, HREADYOUT_I, HRESP_I, HRDATA_I,
    input  HSEL_O, HREADY, HRESP, HRDATA
  );

  modport slave (
    input  HADDR, HTRANS, HREADYOUT_I, HRESP_I, HRDATA_I,
    output HSEL_O, HREADY, HRESP, HRDATA
  );
endinterface
`default_nettype wire

// File: rtl/ahblite_default_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahblite_default_slave
//  Purpose  : Answers unmapped NONSEQ/SEQ transfers with the two-cycle AHB
//             ERROR response (one wait state, then ERROR with HREADYOUT=1).
//  Revision : 1.0  initial release
// ============================================================================
module ahblite_default_slave
  import ahb_pkg::*;
(
  input  wire  clk,
  input  wire  rst_n,
  input  wire  hready,     // system HREADY
  input  wire  miss,       // active transfer to an unmapped address
  output logic hreadyout,
  output logic hresp
);

  ds_state_t r_state;
  ds_state_t w_state_nxt;

  // State register, cleared asynchronously so no ERR2 survives a reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= DS_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decision and response generation
  always_comb begin
    w_state_nxt = r_state;
    hreadyout   = 1'b1;
    hresp       = c_hresp_okay;
    case (r_state)
      DS_IDLE: begin
        if (hready && miss) w_state_nxt = DS_ERR1;
      end
      DS_ERR1: begin
        hreadyout   = 1'b0;
        hresp       = c_hresp_error;
        w_state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        hresp       = c_hresp_error;
        // HREADY is high in ERR2, so a pending miss is a back-to-back error
        w_state_nxt = miss ? DS_ERR1 : DS_IDLE;
      end
      default: w_state_nxt = DS_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ahblite_decoder_mux.sv
`default_nettype none
// ============================================================================
//  Module   : ahblite_decoder_mux
//  Purpose  : Table-driven AHB-Lite address decoder with registered data-phase
//             select, response multiplexer, built-in default slave and
//             unmapped-access error logging.
//  Revision : 1.0  initial release
// ============================================================================
module ahblite_decoder_mux
  import ahb_pkg::*;
#(
  parameter int                     NUM_PORTS = 6,
  parameter int                     DATA_W    = 32,
  parameter logic [32*NUM_PORTS-1:0] PORT_BASE = c_port_base_default,
  parameter logic [32*NUM_PORTS-1:0] PORT_MASK = c_port_mask_default,
  parameter logic [NUM_PORTS-1:0]    PORT_EN   = '1,
  parameter int                     ERR_CNT_W = 16
) (
  input  wire                   HCLK,
  input  wire                   HRESETn,
  ahblite_decoder_mux_if.slave  bus,
  input  wire                   err_clr,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [31:0]           err_addr
);

  logic [NUM_PORTS-1:0] w_hit;
  logic [NUM_PORTS-1:0] w_hsel;
  logic                 w_active;
  logic                 w_miss;
  logic [NUM_PORTS:0]   r_dsel;      // MSB selects the default slave
  logic                 w_hready;
  logic                 w_hresp;
  logic [DATA_W-1:0]    w_hrdata;
  logic                 w_ds_hreadyout;
  logic                 w_ds_hresp;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [31:0]          r_err_addr;

  // Per-port address compare against the base/mask table
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_hit
      assign w_hit[gi] = PORT_EN[gi] &&
        ((bus.HADDR & PORT_MASK[32*gi +: 32]) ==
         (PORT_BASE[32*gi +: 32] & PORT_MASK[32*gi +: 32]));
    end
  endgenerate

  // Lowest-index hit wins so HSEL_O is one-hot or zero
  always_comb begin
    logic found;
    found  = 1'b0;
    w_hsel = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_hit[i] && !found) begin
        w_hsel[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign w_active   = (bus.HTRANS == c_htrans_nonseq) || (bus.HTRANS == c_htrans_seq);
  assign w_miss     = ~|w_hit & w_active;
  assign bus.HSEL_O = w_hsel;

  // Data-phase select: advances only when the current transfer completes
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)      r_dsel <= '0;
    else if (w_hready) r_dsel <= {w_miss, w_hsel & {NUM_PORTS{w_active}}};
  end

  ahblite_default_slave u_default_slave (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .hready    (w_hready),
    .miss      (w_miss),
    .hreadyout (w_ds_hreadyout),
    .hresp     (w_ds_hresp)
  );

  // Return-path multiplexer; an empty data phase reads as OKAY/ready/zero
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = c_hresp_okay;
    w_hrdata = '0;
    if (r_dsel[NUM_PORTS]) begin
      w_hready = w_ds_hreadyout;
      w_hresp  = w_ds_hresp;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (r_dsel[i]) begin
          w_hready = bus.HREADYOUT_I[i];
          w_hresp  = bus.HRESP_I[i];
          w_hrdata = bus.HRDATA_I[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus.HREADY = w_hready;
  assign bus.HRESP  = w_hresp;
  assign bus.HRDATA = w_hrdata;

  // Error logging: clear wins over a simultaneous miss, count saturates
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else if (err_clr) begin
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else if (w_hready && w_miss) begin
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      r_err_addr <= bus.HADDR;
    end
  end

  assign err_cnt  = r_err_cnt;
  assign err_addr = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_ahblite_decoder_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahblite_decoder_mux
//  Purpose  : Directed self-checking bench for ahblite_decoder_mux.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahblite_decoder_mux;
  import ahb_pkg::*;

  logic        HCLK;
  logic        HRESETn;
  logic        err_clr, err_clr2;
  logic [15:0] err_cnt;
  logic [31:0] err_addr;
  logic [1:0]  err_cnt2;
  logic [31:0] err_addr2;
  int          errors;
  int          checks;

  ahblite_decoder_mux_if #(.NUM_PORTS(6), .DATA_W(32)) bus  ();
  ahblite_decoder_mux_if #(.NUM_PORTS(6), .DATA_W(32)) bus2 ();

  ahblite_decoder_mux #(.NUM_PORTS(6), .DATA_W(32), .ERR_CNT_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus.slave),
    .err_clr(err_clr), .err_cnt(err_cnt), .err_addr(err_addr));

  ahblite_decoder_mux #(.NUM_PORTS(6), .DATA_W(32), .PORT_EN(6'b111110), .ERR_CNT_W(2)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus2.slave),
    .err_clr(err_clr2), .err_cnt(err_cnt2), .err_addr(err_addr2));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.HREADY !== 1'b1)   begin errors++; $display("FAIL reset_hready got=%b exp=1", bus.HREADY); end
    checks++; if (bus.HRESP !== 1'b0)    begin errors++; $display("FAIL reset_hresp got=%b exp=0", bus.HRESP); end
    checks++; if (bus.HRDATA !== 32'h0)  begin errors++; $display("FAIL reset_hrdata got=%h exp=0", bus.HRDATA); end
    checks++; if (err_cnt !== 16'h0)     begin errors++; $display("FAIL reset_err_cnt got=%h exp=0", err_cnt); end
    checks++; if (err_addr !== 32'h0)    begin errors++; $display("FAIL reset_err_addr got=%h exp=0", err_addr); end
    tick(); tick();
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_read();
    bus.HRDATA_I[32*1 +: 32] = 32'hCAFE_F00D;
    bus.HADDR = 32'h2000_0010; bus.HTRANS = c_htrans_nonseq;
    #1;
    checks++; if (bus.HSEL_O !== 6'b000010) begin errors++; $display("FAIL read_hsel got=%b exp=000010", bus.HSEL_O); end
    tick();
    bus.HTRANS = c_htrans_idle; bus.HADDR = 32'h0;
    checks++; if (bus.HRDATA !== 32'hCAFE_F00D) begin errors++; $display("FAIL read_hrdata got=%h exp=cafef00d", bus.HRDATA); end
    checks++; if (bus.HRESP !== 1'b0 || bus.HREADY !== 1'b1) begin errors++; $display("FAIL read_resp got=%b/%b exp=1/0", bus.HREADY, bus.HRESP); end
    tick();
    checks++; if (bus.HRDATA !== 32'h0) begin errors++; $display("FAIL read_idle_hrdata got=%h exp=0", bus.HRDATA); end
  endtask

  task automatic test_stall();
    bus.HRDATA_I[32*3 +: 32] = 32'h3333_3333;
    bus.HRDATA_I[32*0 +: 32] = 32'h0A0A_0A0A;
    bus.HADDR = 32'h4000_0014; bus.HTRANS = c_htrans_nonseq;
    #1;
    checks++; if (bus.HSEL_O !== 6'b001000) begin errors++; $display("FAIL stall_hsel got=%b exp=001000", bus.HSEL_O); end
    tick();
    bus.HADDR = 32'h0000_0100; bus.HTRANS = c_htrans_nonseq;
    bus.HREADYOUT_I[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (bus.HREADY !== 1'b0) begin errors++; $display("FAIL stall_hready_%0d got=%b exp=0", k, bus.HREADY); end
      checks++; if (bus.HRDATA !== 32'h3333_3333) begin errors++; $display("FAIL stall_hold_%0d got=%h exp=33333333", k, bus.HRDATA); end
      tick();
    end
    bus.HREADYOUT_I[3] = 1'b1;
    #1;
    checks++; if (bus.HREADY !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", bus.HREADY); end
    tick();
    bus.HTRANS = c_htrans_idle;
    checks++; if (bus.HRDATA !== 32'h0A0A_0A0A) begin errors++; $display("FAIL stall_next_hrdata got=%h exp=0a0a0a0a", bus.HRDATA); end
    tick();
  endtask

  task automatic test_unmapped();
    bus.HADDR = 32'h3000_0000; bus.HTRANS = c_htrans_nonseq;
    #1;
    checks++; if (bus.HSEL_O !== 6'b000000) begin errors++; $display("FAIL unm_hsel got=%b exp=0", bus.HSEL_O); end
    tick();
    bus.HTRANS = c_htrans_idle; bus.HADDR = 32'h0;
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b01) begin errors++; $display("FAIL unm_err1 got=%b exp=01", {bus.HREADY, bus.HRESP}); end
    tick();
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b11) begin errors++; $display("FAIL unm_err2 got=%b exp=11", {bus.HREADY, bus.HRESP}); end
    checks++; if (bus.HRDATA !== 32'h0) begin errors++; $display("FAIL unm_hrdata got=%h exp=0", bus.HRDATA); end
    tick();
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b10) begin errors++; $display("FAIL unm_idle got=%b exp=10", {bus.HREADY, bus.HRESP}); end
    checks++; if (err_cnt !== 16'd1) begin errors++; $display("FAIL unm_err_cnt got=%0d exp=1", err_cnt); end
    checks++; if (err_addr !== 32'h3000_0000) begin errors++; $display("FAIL unm_err_addr got=%h exp=30000000", err_addr); end
  endtask

  task automatic test_back_to_back();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_cnt !== 16'd0 || err_addr !== 32'h0) begin errors++; $display("FAIL b2b_clear got=%0d/%h exp=0/0", err_cnt, err_addr); end
    bus.HADDR = 32'h7000_0000; bus.HTRANS = c_htrans_nonseq;
    tick();
    bus.HADDR = 32'h7000_0004;
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b01) begin errors++; $display("FAIL b2b_err1a got=%b exp=01", {bus.HREADY, bus.HRESP}); end
    tick();
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b11) begin errors++; $display("FAIL b2b_err2a got=%b exp=11", {bus.HREADY, bus.HRESP}); end
    tick();
    bus.HTRANS = c_htrans_idle; bus.HADDR = 32'h7000_0000;
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b01) begin errors++; $display("FAIL b2b_err1b got=%b exp=01", {bus.HREADY, bus.HRESP}); end
    tick();
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b11) begin errors++; $display("FAIL b2b_err2b got=%b exp=11", {bus.HREADY, bus.HRESP}); end
    tick();
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b10) begin errors++; $display("FAIL b2b_idle got=%b exp=10", {bus.HREADY, bus.HRESP}); end
    checks++; if (err_cnt !== 16'd2) begin errors++; $display("FAIL b2b_err_cnt got=%0d exp=2", err_cnt); end
    checks++; if (err_addr !== 32'h7000_0004) begin errors++; $display("FAIL b2b_err_addr got=%h exp=70000004", err_addr); end
    tick();
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b10 || err_cnt !== 16'd2) begin errors++; $display("FAIL idle_unmapped got=%b cnt=%0d exp=10 cnt=2", {bus.HREADY, bus.HRESP}, err_cnt); end
  endtask

  task automatic test_port_disable_saturate();
    bus2.HADDR = 32'h0; bus2.HTRANS = c_htrans_nonseq;
    #1;
    checks++; if (bus2.HSEL_O !== 6'b000000) begin errors++; $display("FAIL dis_hsel got=%b exp=0", bus2.HSEL_O); end
    tick();
    bus2.HTRANS = c_htrans_idle;
    checks++; if ({bus2.HREADY, bus2.HRESP} !== 2'b01) begin errors++; $display("FAIL dis_err1 got=%b exp=01", {bus2.HREADY, bus2.HRESP}); end
    tick();
    checks++; if ({bus2.HREADY, bus2.HRESP} !== 2'b11) begin errors++; $display("FAIL dis_err2 got=%b exp=11", {bus2.HREADY, bus2.HRESP}); end
    tick();
    checks++; if (err_cnt2 !== 2'd1) begin errors++; $display("FAIL dis_err_cnt got=%0d exp=1", err_cnt2); end
    for (int k = 0; k < 4; k++) begin
      bus2.HTRANS = c_htrans_nonseq;
      tick();
      bus2.HTRANS = c_htrans_idle;
      tick(); tick();
    end
    checks++; if (err_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_err_cnt got=%0d exp=3", err_cnt2); end
    bus2.HTRANS = c_htrans_nonseq; err_clr2 = 1'b1;
    tick();
    bus2.HTRANS = c_htrans_idle; err_clr2 = 1'b0;
    checks++; if (err_cnt2 !== 2'd0 || err_addr2 !== 32'h0) begin errors++; $display("FAIL clr_miss got=%0d/%h exp=0/0", err_cnt2, err_addr2); end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    bus.HADDR = 32'h3000_0000; bus.HTRANS = c_htrans_nonseq;
    tick();
    bus.HTRANS = c_htrans_idle; bus.HADDR = 32'h0;
    checks++; if (bus.HREADY !== 1'b0) begin errors++; $display("FAIL rst_pre_err1 got=%b exp=0", bus.HREADY); end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b10 || bus.HRDATA !== 32'h0) begin errors++; $display("FAIL rst_async got=%b/%h exp=10/0", {bus.HREADY, bus.HRESP}, bus.HRDATA); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); end
    tick();
    HRESETn = 1'b1;
    tick();
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b10) begin errors++; $display("FAIL rst_no_err2 got=%b exp=10", {bus.HREADY, bus.HRESP}); end
    tick();
    checks++; if ({bus.HREADY, bus.HRESP} !== 2'b10) begin errors++; $display("FAIL rst_idle got=%b exp=10", {bus.HREADY, bus.HRESP}); end
  endtask

  initial begin
    errors = 0; checks = 0;
    HRESETn = 1'b0; err_clr = 1'b0; err_clr2 = 1'b0;
    bus.HADDR = 32'h0;  bus.HTRANS = c_htrans_idle;
    bus.HREADYOUT_I = '1; bus.HRESP_I = '0; bus.HRDATA_I = '0;
    bus2.HADDR = 32'h0; bus2.HTRANS = c_htrans_idle;
    bus2.HREADYOUT_I = '1; bus2.HRESP_I = '0; bus2.HRDATA_I = '0;
    test_reset();
    test_read();
    test_stall();
    test_unmapped();
    test_back_to_back();
    test_port_disable_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahblite_decoder_mux.md
Name: ahblite_decoder_mux

Overview:
- Parametrised AHB-Lite interconnect slice for the single-manager bus (Cortex-M0 to RAMCODE, RAMDATA, WaterLight, UART, SPI, FM_HW, and later slaves).
- Replaces the fixed address decoder with three functions:
  - table-driven address decode over NUM_PORTS slaves;
  - registered data-phase select with HRDATA/HREADY/HRESP return multiplexing;
  - a built-in default slave that returns the two-cycle AHB ERROR response for unmapped accesses, plus an error counter and error-address capture.

Parameters:
- NUM_PORTS, 6, number of subordinate ports (1..16).
- DATA_W, 32, HRDATA width.
- PORT_BASE, {6 x 32-bit: 0x00000000, 0x20000000, 0x40000000, 0x40000010, 0x50000010, 0x60000000}, packed base address per port; port i occupies bits [32*i+31:32*i].
- PORT_MASK, {6 x 32-bit: 0xFFFF0000, 0xFFFF0000, 0xFFFFFFF0, 0xFFFFFFF0, 0xFFFFFFF0, 0xFFFE0000}, packed compare mask per port.
- PORT_EN, 6'b111111, per-port enable; a disabled port never hits.
- ERR_CNT_W, 16, width of the unmapped-access error counter.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  asynchronous active-low reset.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  transfer type.
- HSEL_O  out  NUM_PORTS  one-hot address-phase select per port.
- HREADYOUT_I  in  NUM_PORTS  per-port HREADYOUT.
- HRESP_I  in  NUM_PORTS  per-port HRESP.
- HRDATA_I  in  NUM_PORTS*DATA_W  per-port read data, packed.
- HREADY  out  1  system HREADY, fed back to the manager and to all slaves.
- HRESP  out  1  multiplexed response.
- HRDATA  out  DATA_W  multiplexed read data.
- err_clr  in  1  synchronous clear of err_cnt and err_addr.
- err_cnt  out  ERR_CNT_W  saturating count of unmapped transfers.
- err_addr  out  32  HADDR of the most recent unmapped transfer.

Behaviour:
- Decode (combinational):
  - hit[i] = PORT_EN[i] & ((HADDR & MASK_i) == (BASE_i & MASK_i)).
  - Overlapping hits resolve to the lowest index, so HSEL_O is always one-hot or zero.
  - HSEL_O is independent of HTRANS; slaves qualify it with HTRANS and HREADY.
- miss = ~|hit & HTRANS[1], i.e. NONSEQ or SEQ to an unmapped address. IDLE/BUSY to an unmapped address is not an error.
- Data-phase register:
  - dsel_q (NUM_PORTS+1 bits; the extra bit is the default slave) loads {miss, HSEL_O & {NUM_PORTS{HTRANS[1]}}} when HREADY=1, and holds otherwise.
  - Reset value: 0.
- Output mux:
  - When dsel_q selects port p: HREADY = HREADYOUT_I[p], HRESP = HRESP_I[p], HRDATA = HRDATA_I[p].
  - When dsel_q selects the default slave, outputs come from the default-slave FSM, with HRDATA = 0.
  - When dsel_q = 0: HREADY = 1, HRESP = 0, HRDATA = 0.
  - These are also the reset values of every output.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADY=1, HRESP=0. If HREADY=1 and miss, go to ERR1.
  - ERR1: HREADY=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADY=1, HRESP=1. If miss, go to ERR1 (back-to-back errors); otherwise go to IDLE.
  - Net latency: one wait state, then completion with ERROR, per AHB-Lite.
- Error logging:
  - On each cycle with HREADY=1 and miss: err_cnt increments, saturating at all-ones, and err_addr captures HADDR.
  - err_clr has priority: err_cnt and err_addr go to 0, and any simultaneous miss in that cycle is not counted.
  - Reset values: err_cnt = 0, err_addr = 0.
- Slave stalls: while HREADY=0, dsel_q and the FSM next-transfer decision are frozen. The address phase on HADDR is not sampled until HREADY=1.
- Reset mid-transfer: asynchronous; dsel_q goes to 0 and the FSM to IDLE immediately, with outputs at their reset values.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings IDLE/BUSY/NONSEQ/SEQ;
  - HRESP OKAY/ERROR;
  - default-slave state encoding;
  - the default PORT_BASE/PORT_MASK memory-map constants, so software headers and the testbench share one map.
- One sub-module: ahblite_default_slave, containing the FSM and the HREADYOUT/HRESP generation.
- The decoder, data-phase register, mux and error logging stay in the top module.

Test Plan:
- Reset, then NONSEQ read at 0x20000010 with slave 1 HRDATA=0xCAFEF00D and HREADYOUT=1 -> HSEL_O=6'b000010 in the address phase; HRDATA=0xCAFEF00D with HRESP=0 in the next cycle.
- NONSEQ to 0x40000014 while slave 3 holds HREADYOUT=0 for 3 cycles -> HREADY=0 for exactly 3 cycles; dsel_q held; the next address (0x00000100) is not registered until release.
- NONSEQ to unmapped 0x30000000 -> HREADY/HRESP sequence (0,1) then (1,1); err_cnt=1; err_addr=0x30000000.
- Two back-to-back NONSEQ transfers to 0x70000000 and 0x70000004 -> sequence ERR1, ERR2, ERR1, ERR2; err_cnt=2; err_addr=0x70000004. IDLE to 0x70000000 -> OKAY and no count.
- PORT_EN=6'b111110 build, access to 0x00000000 -> HSEL_O=0 and an ERROR response; ERR_CNT_W=2 with 5 misses -> err_cnt saturates at 3; err_clr together with a miss -> err_cnt=0.
- Assert HRESETn low during ERR1 -> HREADY=1, HRESP=0, HRDATA=0, err_cnt=0 asynchronously, with no remaining ERR2 cycle after release.
